// File: rtl/spi_slave_ctrl_if.sv
// Signal bundle for spi_slave_ctrl: SPI bus pins plus the host-side tx/rx word port.
interface spi_slave_ctrl_if #(
    parameter int DATA_W = 16
);
    logic              en;
    logic              cpol;
    logic              cpha;
    logic [3:0]        xfer_len;
    logic              ss_n;
    logic              sck;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              underrun;

    modport slave (
        input  en, cpol, cpha, xfer_len, ss_n, sck, mosi, tx_data, tx_load,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun
    );

    modport master (
        output en, cpol, cpha, xfer_len, ss_n, sck, mosi, tx_data, tx_load,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, busy, underrun
    );
endinterface

// File: rtl/spi_slave_ctrl.sv
// SPI slave, modes 0-3, 1..16-bit MSB-first frames, single-word tx buffer, oversampled bus.
// Optional sticky underrun flag built only when SPI_SLAVE_UNDERRUN_EN is defined.
module spi_slave_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    spi_slave_ctrl_if.slave  bus
);
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t                 state_reg;
    logic [SYNC_STAGES-1:0] ss_sync_reg;
    logic [SYNC_STAGES-1:0] sck_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic [SYNC_STAGES-1:0] flush_reg;
    logic                   sck_prev_reg;
    logic                   cpol_reg;
    logic                   cpha_reg;
    logic [3:0]             len_reg;
    logic [DATA_W-1:0]      shift_reg;
    logic [CNT_W-1:0]       bit_cnt_reg;
    logic                   miso_reg;
    logic                   miso_oe_reg;
    logic [DATA_W-1:0]      rx_data_reg;
    logic                   rx_valid_reg;
    logic [DATA_W-1:0]      tx_buf_reg;
    logic                   tx_ready_reg;
    logic                   armed_reg;

    logic                   ss_s, sck_s, mosi_s, sync_live;
    logic                   lead_edge, trail_edge, sample_edge, drive_edge;
    logic                   start, tx_accept;
    logic [CNT_W-1:0]       frame_bits;
    logic [DATA_W-1:0]      len_mask;

    assign ss_s      = ss_sync_reg[SYNC_STAGES-1];
    assign sck_s     = sck_sync_reg[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
    // Synchronizer outputs are only trusted once the reset values have flushed out.
    assign sync_live = flush_reg[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync_reg   <= '1;
            sck_sync_reg  <= '0;
            mosi_sync_reg <= '0;
            flush_reg     <= '0;
            sck_prev_reg  <= 1'b0;
        end else begin
            ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0], bus.ss_n};
            sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], bus.sck};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], bus.mosi};
            flush_reg     <= {flush_reg[SYNC_STAGES-2:0], 1'b1};
            sck_prev_reg  <= sck_s;
        end
    end

    assign lead_edge   = (sck_prev_reg == cpol_reg) && (sck_s != cpol_reg);
    assign trail_edge  = (sck_prev_reg != cpol_reg) && (sck_s == cpol_reg);
    assign sample_edge = cpha_reg ? trail_edge : lead_edge;
    assign drive_edge  = cpha_reg ? lead_edge : trail_edge;

    assign start      = (state_reg == S_IDLE) && !ss_s && bus.en && armed_reg;
    // The buffer is being emptied into the shifter at frame start, so a load then always lands.
    assign tx_accept  = bus.tx_load && (tx_ready_reg || start);
    assign frame_bits = {1'b0, len_reg} + CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_len_mask
            assign len_mask[gi] = (CNT_W'(gi) <= {1'b0, len_reg});
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cpol_reg     <= 1'b0;
            cpha_reg     <= 1'b0;
            len_reg      <= '0;
            shift_reg    <= '0;
            bit_cnt_reg  <= '0;
            miso_reg     <= 1'b0;
            miso_oe_reg  <= 1'b0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            tx_buf_reg   <= '0;
            tx_ready_reg <= 1'b1;
            armed_reg    <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            // A select held low across reset or an enable abort must be released before re-arming.
            miso_oe_reg  <= bus.en && !ss_s && (armed_reg || state_reg != S_IDLE);
            if (sync_live && ss_s) begin
                armed_reg <= 1'b1;
            end

            if (tx_accept) begin
                tx_buf_reg   <= bus.tx_data;
                tx_ready_reg <= 1'b0;
            end else if (start) begin
                tx_ready_reg <= 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg   <= S_SHIFT;
                        cpol_reg    <= bus.cpol;
                        cpha_reg    <= bus.cpha;
                        len_reg     <= bus.xfer_len;
                        shift_reg   <= tx_ready_reg ? '0 : tx_buf_reg;
                        miso_reg    <= tx_ready_reg ? 1'b0 : tx_buf_reg[bus.xfer_len];
                        bit_cnt_reg <= '0;
                        armed_reg   <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (ss_s || !bus.en) begin
                        state_reg <= S_IDLE;
                    end else if (bit_cnt_reg == frame_bits) begin
                        rx_data_reg  <= shift_reg & len_mask;
                        rx_valid_reg <= 1'b1;
                        state_reg    <= S_DONE;
                    end else begin
                        if (sample_edge) begin
                            shift_reg   <= {shift_reg[DATA_W-2:0], mosi_s};
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end
                        // Samples shift the next outgoing bit into position len_reg.
                        if (drive_edge) begin
                            miso_reg <= shift_reg[len_reg];
                        end
                    end
                end
                S_DONE: begin
                    if (ss_s) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    logic underrun_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_reg <= 1'b0;
        end else if (start && tx_ready_reg) begin
            underrun_reg <= 1'b1;
        end else if (tx_accept) begin
            underrun_reg <= 1'b0;
        end
    end

    assign bus.underrun = underrun_reg;
`else
    assign bus.underrun = 1'b0;
`endif

    assign bus.miso     = miso_oe_reg & miso_reg;
    assign bus.miso_oe  = miso_oe_reg;
    assign bus.tx_ready = tx_ready_reg;
    assign bus.rx_data  = rx_data_reg;
    assign bus.rx_valid = rx_valid_reg;
    assign bus.busy     = (state_reg != S_IDLE);
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: bit-banged SPI master, hand-computed expected words.
module tb_spi_slave_ctrl;
    localparam int SYNC = 2;
    localparam int DW   = 16;
    localparam int HALF = 6;
`ifdef SPI_SLAVE_UNDERRUN_EN
    localparam logic EXP_UR = 1'b1;
`else
    localparam logic EXP_UR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   rxv_cnt = 0;

    spi_slave_ctrl_if #(.DATA_W(DW)) bus ();

    spi_slave_ctrl #(.SYNC_STAGES(SYNC), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.rx_valid === 1'b1) rxv_cnt++;

    task automatic load_word(input logic [15:0] w);
        @(negedge clk);
        bus.tx_data = w;
        bus.tx_load = 1'b1;
        @(negedge clk);
        bus.tx_load = 1'b0;
        $display("load tx_data=%h", w);
    endtask

    // Runs nbits sck cycles; optionally pulses tx_load in the frame-start cycle; raises ss_n unless keep_ss.
    task automatic spi_frame(input logic pol, input logic pha, input logic [3:0] len,
                             input logic [15:0] mosi_w, input int nbits, input logic ld,
                             input logic [15:0] ld_word, input logic keep_ss,
                             output logic [15:0] miso_w, output logic bsy);
        int b;
        miso_w = '0;
        @(negedge clk);
        bus.cpol = pol;
        bus.cpha = pha;
        bus.xfer_len = len;
        bus.sck = pol;
        bus.mosi = mosi_w[len];
        repeat (HALF) @(negedge clk);
        bus.ss_n = 1'b0;
        if (ld) begin
            repeat (SYNC) @(negedge clk);
            bus.tx_data = ld_word;
            bus.tx_load = 1'b1;
            @(negedge clk);
            bus.tx_load = 1'b0;
            repeat (HALF - SYNC - 1) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
        for (int i = 0; i < nbits; i++) begin
            b = int'(len) - i;
            if (pha) bus.mosi = mosi_w[b];
            else miso_w = {miso_w[14:0], bus.miso};
            bus.sck = ~pol;
            repeat (HALF) @(negedge clk);
            if (pha) miso_w = {miso_w[14:0], bus.miso};
            bus.sck = pol;
            if (!pha && b > 0) bus.mosi = mosi_w[b-1];
            repeat (HALF) @(negedge clk);
        end
        bsy = bus.busy;
        if (!keep_ss) bus.ss_n = 1'b1;
        $display("frame cpol=%0d cpha=%0d len=%0d bits=%0d mosi=%h miso=%h", pol, pha, len, nbits, mosi_w, miso_w);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (bus.miso !== 1'b0) begin bad++; $display("FAIL reset_miso got=%h want=0", bus.miso); end
        total++; if (bus.miso_oe !== 1'b0) begin bad++; $display("FAIL reset_miso_oe got=%h want=0", bus.miso_oe); end
        total++; if (bus.rx_data !== 16'h0000) begin bad++; $display("FAIL reset_rx_data got=%h want=0000", bus.rx_data); end
        total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%h want=0", bus.rx_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%h want=0", bus.busy); end
        total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL reset_tx_ready got=%h want=1", bus.tx_ready); end
        total++; if (bus.underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%h want=0", bus.underrun); end
    endtask

    task automatic test_mode0();
        logic [15:0] m;
        logic        bsy;
        load_word(16'h00A5);
        total++; if (bus.tx_ready !== 1'b0) begin bad++; $display("FAIL m0_tx_ready_after_load got=%h want=0", bus.tx_ready); end
        rxv_cnt = 0;
        spi_frame(1'b0, 1'b0, 4'd7, 16'h003C, 8, 1'b0, 16'h0, 1'b0, m, bsy);
        repeat (HALF) @(negedge clk);
        total++; if (m !== 16'h00A5) begin bad++; $display("FAIL m0_miso_word got=%h want=00a5", m); end
        total++; if (bsy !== 1'b1) begin bad++; $display("FAIL m0_busy_in_frame got=%h want=1", bsy); end
        total++; if (bus.rx_data !== 16'h003C) begin bad++; $display("FAIL m0_rx_data got=%h want=003c", bus.rx_data); end
        total++; if (rxv_cnt !== 1) begin bad++; $display("FAIL m0_rx_valid_pulses got=%0d want=1", rxv_cnt); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL m0_busy_after got=%h want=0", bus.busy); end
        total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL m0_tx_ready_after got=%h want=1", bus.tx_ready); end
        total++; if (bus.miso_oe !== 1'b0) begin bad++; $display("FAIL m0_miso_oe_after got=%h want=0", bus.miso_oe); end
    endtask

    task automatic test_mode3();
        logic [15:0] m;
        logic        bsy;
        load_word(16'hBEEF);
        rxv_cnt = 0;
        spi_frame(1'b1, 1'b1, 4'd15, 16'h1234, 16, 1'b0, 16'h0, 1'b0, m, bsy);
        repeat (HALF) @(negedge clk);
        total++; if (m !== 16'hBEEF) begin bad++; $display("FAIL m3_miso_word got=%h want=beef", m); end
        total++; if (bus.rx_data !== 16'h1234) begin bad++; $display("FAIL m3_rx_data got=%h want=1234", bus.rx_data); end
        total++; if (rxv_cnt !== 1) begin bad++; $display("FAIL m3_rx_valid_pulses got=%0d want=1", rxv_cnt); end
    endtask

    task automatic test_abort();
        logic [15:0] m;
        logic        bsy;
        load_word(16'h0055);
        rxv_cnt = 0;
        spi_frame(1'b0, 1'b0, 4'd7, 16'h00FF, 5, 1'b0, 16'h0, 1'b0, m, bsy);
        total++; if (bsy !== 1'b1) begin bad++; $display("FAIL ab_busy_before got=%h want=1", bsy); end
        for (int k = 0; k <= SYNC; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) break;
        end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ab_busy_drop got=%h want=0", bus.busy); end
        repeat (HALF) @(negedge clk);
        total++; if (rxv_cnt !== 0) begin bad++; $display("FAIL ab_rx_valid_pulses got=%0d want=0", rxv_cnt); end
        total++; if (bus.rx_data !== 16'h1234) begin bad++; $display("FAIL ab_rx_data got=%h want=1234", bus.rx_data); end
    endtask

    task automatic test_underrun();
        logic [15:0] m;
        logic        bsy;
        total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL ur_tx_ready_before got=%h want=1", bus.tx_ready); end
        spi_frame(1'b0, 1'b0, 4'd7, 16'h0081, 8, 1'b0, 16'h0, 1'b0, m, bsy);
        repeat (HALF) @(negedge clk);
        total++; if (m !== 16'h0000) begin bad++; $display("FAIL ur_miso_word got=%h want=0000", m); end
        total++; if (bus.rx_data !== 16'h0081) begin bad++; $display("FAIL ur_rx_data got=%h want=0081", bus.rx_data); end
        total++; if (bus.underrun !== EXP_UR) begin bad++; $display("FAIL ur_flag_set got=%h want=%h", bus.underrun, EXP_UR); end
        load_word(16'h00C3);
        total++; if (bus.underrun !== 1'b0) begin bad++; $display("FAIL ur_flag_clear got=%h want=0", bus.underrun); end
        total++; if (bus.tx_ready !== 1'b0) begin bad++; $display("FAIL ur_tx_ready_after_load got=%h want=0", bus.tx_ready); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] m;
        logic        bsy;
        spi_frame(1'b0, 1'b1, 4'd7, 16'h0066, 8, 1'b1, 16'h005A, 1'b0, m, bsy);
        repeat (HALF) @(negedge clk);
        total++; if (m !== 16'h00C3) begin bad++; $display("FAIL b2b_first_miso got=%h want=00c3", m); end
        total++; if (bus.rx_data !== 16'h0066) begin bad++; $display("FAIL b2b_first_rx got=%h want=0066", bus.rx_data); end
        total++; if (bus.tx_ready !== 1'b0) begin bad++; $display("FAIL b2b_tx_ready_between got=%h want=0", bus.tx_ready); end
        spi_frame(1'b1, 1'b0, 4'd7, 16'h0099, 8, 1'b0, 16'h0, 1'b0, m, bsy);
        repeat (HALF) @(negedge clk);
        total++; if (m !== 16'h005A) begin bad++; $display("FAIL b2b_second_miso got=%h want=005a", m); end
        total++; if (bus.rx_data !== 16'h0099) begin bad++; $display("FAIL b2b_second_rx got=%h want=0099", bus.rx_data); end
        total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL b2b_tx_ready_after got=%h want=1", bus.tx_ready); end
        total++; if (bus.underrun !== 1'b0) begin bad++; $display("FAIL b2b_underrun got=%h want=0", bus.underrun); end
    endtask

    task automatic test_short_frame();
        logic [15:0] m;
        logic        bsy;
        load_word(16'hFFF5);
        spi_frame(1'b0, 1'b0, 4'd3, 16'h000A, 4, 1'b0, 16'h0, 1'b0, m, bsy);
        repeat (HALF) @(negedge clk);
        total++; if (m !== 16'h0005) begin bad++; $display("FAIL short_miso got=%h want=0005", m); end
        total++; if (bus.rx_data !== 16'h000A) begin bad++; $display("FAIL short_rx_upper_zero got=%h want=000a", bus.rx_data); end
    endtask

    task automatic test_enable();
        @(negedge clk);
        bus.en = 1'b0;
        bus.ss_n = 1'b0;
        repeat (HALF) @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL en_low_busy got=%h want=0", bus.busy); end
        total++; if (bus.miso_oe !== 1'b0) begin bad++; $display("FAIL en_low_miso_oe got=%h want=0", bus.miso_oe); end
        bus.ss_n = 1'b1;
        repeat (HALF) @(negedge clk);
        bus.en = 1'b1;
        $display("enable low with ss_n low: busy=%h miso_oe=%h", bus.busy, bus.miso_oe);
    endtask

    task automatic test_rst_midframe();
        logic [15:0] m;
        logic        bsy;
        load_word(16'h00F0);
        spi_frame(1'b0, 1'b0, 4'd7, 16'h00AA, 3, 1'b0, 16'h0, 1'b1, m, bsy);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rxv_cnt = 0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%h want=0", bus.busy); end
        total++; if (bus.miso !== 1'b0) begin bad++; $display("FAIL rst_mid_miso got=%h want=0", bus.miso); end
        total++; if (bus.rx_data !== 16'h0000) begin bad++; $display("FAIL rst_mid_rx_data got=%h want=0000", bus.rx_data); end
        total++; if (bus.tx_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_tx_ready got=%h want=1", bus.tx_ready); end
        for (int i = 0; i < 8; i++) begin
            bus.sck = ~bus.sck;
            repeat (HALF) @(negedge clk);
        end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_no_rearm_busy got=%h want=0", bus.busy); end
        total++; if (bus.miso_oe !== 1'b0) begin bad++; $display("FAIL rst_mid_no_rearm_oe got=%h want=0", bus.miso_oe); end
        total++; if (rxv_cnt !== 0) begin bad++; $display("FAIL rst_mid_no_rx_valid got=%0d want=0", rxv_cnt); end
        bus.ss_n = 1'b1;
        repeat (HALF) @(negedge clk);
        load_word(16'h00A5);
        spi_frame(1'b0, 1'b0, 4'd7, 16'h00E7, 8, 1'b0, 16'h0, 1'b0, m, bsy);
        repeat (HALF) @(negedge clk);
        total++; if (m !== 16'h00A5) begin bad++; $display("FAIL rst_rearm_miso got=%h want=00a5", m); end
        total++; if (bus.rx_data !== 16'h00E7) begin bad++; $display("FAIL rst_rearm_rx got=%h want=00e7", bus.rx_data); end
        total++; if (rxv_cnt !== 1) begin bad++; $display("FAIL rst_rearm_rx_valid got=%0d want=1", rxv_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b1;
        bus.cpol = 1'b0;
        bus.cpha = 1'b0;
        bus.xfer_len = 4'd7;
        bus.ss_n = 1'b1;
        bus.sck = 1'b0;
        bus.mosi = 1'b0;
        bus.tx_data = '0;
        bus.tx_load = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        repeat (HALF) @(negedge clk);
        test_mode0();
        test_mode3();
        test_abort();
        test_underrun();
        test_back_to_back();
        test_short_frame();
        test_enable();
        test_rst_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
